// File: rtl/counter_ctrl_pkg.sv
// Shared types and default sizes for the counter run controller and its counter datapath.
package counter_ctrl_pkg;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned DEF_RUNW  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/counter_run_controller_sync_counter.sv
// WIDTH-bit synchronous up-counter with clear and enable; clear wins over enable.
module sync_counter
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             enable_i,
  output logic [WIDTH-1:0] count_o
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // next count: clear, step or hold
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = {WIDTH{1'b0}};
    end else if (enable_i) begin
      count_d = count_q + ONE;
    end else begin
      count_d = count_q;
    end
  end

  // count register
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= {WIDTH{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/counter_run_controller.sv
// Run sequencer for a synchronous counter: load, count to a latched limit, pulse done,
// optionally reload; supports pause, abort and a tally of completed runs.
module counter_run_controller
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned RUNW  = DEF_RUNW
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_i,
  input  logic [WIDTH-1:0] limit_i,
  input  logic             repeat_i,
  input  logic             pause_i,
  input  logic             abort_i,
  output logic [WIDTH-1:0] count_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [RUNW-1:0]  runs_o
);

  localparam logic [RUNW-1:0] RUNS_ONE = {{(RUNW-1){1'b0}}, 1'b1};

  ctrl_state_e      state_q, state_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             repeat_q, repeat_d;
  logic [RUNW-1:0]  runs_q, runs_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] count_s;
  logic             cnt_clear_s;
  logic             cnt_enable_s;
  logic             at_limit_s;

  sync_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clock    (clock),
    .reset    (reset),
    .clear_i  (cnt_clear_s),
    .enable_i (cnt_enable_s),
    .count_o  (count_s)
  );

  assign at_limit_s = (count_s == limit_q);

  // next-state, counter control, latches and run tally
  always_comb begin
    state_d      = state_q;
    limit_d      = limit_q;
    repeat_d     = repeat_q;
    runs_d       = runs_q;
    cnt_clear_s  = 1'b0;
    cnt_enable_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i && !abort_i) begin
          state_d  = ST_LOAD;
          limit_d  = limit_i;
          repeat_d = repeat_i;
          runs_d   = {RUNW{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        cnt_clear_s = 1'b1;
        if (abort_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // abort outranks terminal detection and pause
        if (abort_i) begin
          state_d     = ST_IDLE;
          cnt_clear_s = 1'b1;
        end else if (at_limit_s) begin
          state_d = ST_DONE;
          runs_d  = runs_q + RUNS_ONE;
        end else if (!pause_i) begin
          cnt_enable_s = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (abort_i) begin
          state_d     = ST_IDLE;
          cnt_clear_s = 1'b1;
        end else if (repeat_q) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        cnt_clear_s = 1'b1;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // controller registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      limit_q  <= {WIDTH{1'b0}};
      repeat_q <= 1'b0;
      runs_q   <= {RUNW{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      limit_q  <= limit_d;
      repeat_q <= repeat_d;
      runs_q   <= runs_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign count_o = count_s;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign runs_o  = runs_q;

endmodule

// File: tb/tb_counter_run_controller.sv
// Randomised and directed bench for counter_run_controller against a run-level reference model.
module tb_counter_run_controller;

  localparam int W = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] limit = '0;
  logic         rep_in = 1'b0;
  logic         pause = 1'b0;
  logic         abort = 1'b0;

  logic [W-1:0] count_a, count_b;
  logic         busy_a, busy_b, done_a, done_b;
  logic [7:0]   runs_a;
  logic [1:0]   runs_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  counter_run_controller #(.WIDTH(W), .RUNW(8)) dut (
    .clock(clock), .reset(reset), .start_i(start), .limit_i(limit), .repeat_i(rep_in),
    .pause_i(pause), .abort_i(abort), .count_o(count_a), .busy_o(busy_a),
    .done_o(done_a), .runs_o(runs_a));

  counter_run_controller #(.WIDTH(W), .RUNW(2)) dut_w2 (
    .clock(clock), .reset(reset), .start_i(start), .limit_i(limit), .repeat_i(rep_in),
    .pause_i(pause), .abort_i(abort), .count_o(count_b), .busy_o(busy_b),
    .done_o(done_b), .runs_o(runs_b));

  // Reference model: a run is one load cycle, counting cycles up to the limit, one done cycle.
  localparam int PH_IDLE = 0, PH_LOAD = 1, PH_COUNT = 2, PH_FINISHED = 3;
  int m_phase = PH_IDLE;
  int m_count = 0, m_lim = 0, m_runs = 0;
  bit m_rep = 0, m_done = 0, m_valid = 0;

  always @(posedge clock) begin
    if (reset) begin
      m_phase <= PH_IDLE; m_count <= 0; m_lim <= 0; m_rep <= 0;
      m_runs <= 0; m_done <= 0; m_valid <= 1;
    end else begin
      m_done <= 0;
      if (m_phase == PH_IDLE) begin
        if (start && !abort) begin
          m_lim <= int'(limit); m_rep <= rep_in; m_runs <= 0; m_phase <= PH_LOAD;
        end
      end else if (abort) begin
        m_phase <= PH_IDLE; m_count <= 0;
      end else if (m_phase == PH_LOAD) begin
        m_count <= 0; m_phase <= PH_COUNT;
      end else if (m_phase == PH_COUNT) begin
        if (m_count == m_lim) begin
          m_phase <= PH_FINISHED; m_done <= 1; m_runs <= m_runs + 1;
        end else if (!pause) begin
          m_count <= m_count + 1;
        end
      end else begin
        m_phase <= m_rep ? PH_LOAD : PH_IDLE;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // every-cycle comparison of both instances against the model
  always @(negedge clock) begin
    if (m_valid) begin
      check("count", 32'(count_a), 32'(m_count));
      check("busy", 32'(busy_a), 32'(m_phase != PH_IDLE));
      check("done", 32'(done_a), 32'(m_done));
      check("runs", 32'(runs_a), 32'(m_runs % 256));
      check("count_w2", 32'(count_b), 32'(m_count));
      check("busy_w2", 32'(busy_b), 32'(m_phase != PH_IDLE));
      check("done_w2", 32'(done_b), 32'(m_done));
      check("runs_w2", 32'(runs_b), 32'(m_runs % 4));
    end
  end

  task automatic cyc();
    @(negedge clock);
  endtask

  // counts cycles from n0 until done is seen; -1 if it never appears
  task automatic wait_done(input int n0, input int maxc, output int n);
    int c;
    bit seen;
    c = n0;
    seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      cyc();
      c++;
      if (done_a === 1'b1) seen = 1'b1;
    end
    n = seen ? c : -1;
  endtask

  task automatic start_run(input int lim, input bit rp);
    limit = W'(lim); rep_in = rp; start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    int n, seen_done;
    bit hit;
    cyc(); cyc();
    check("rst_count", 32'(count_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_runs", 32'(runs_a), 32'd0);
    reset = 1'b0;

    // limit 5, single run
    start_run(5, 1'b0);
    check("t1_busy_after_start", 32'(busy_a), 32'd1);
    wait_done(1, 30, n);
    check("t1_done_latency", n, 32'd8);
    check("t1_count_at_done", 32'(count_a), 32'd5);
    check("t1_runs", 32'(runs_a), 32'd1);
    cyc();
    check("t1_busy_falls", 32'(busy_a), 32'd0);

    // limit 0
    start_run(0, 1'b0);
    wait_done(1, 30, n);
    check("t2_done_latency", n, 32'd3);
    check("t2_count", 32'(count_a), 32'd0);
    cyc();

    // limit 3 with four paused cycles
    limit = 4'd3; rep_in = 1'b0; start = 1'b1; n = -1;
    for (int i = 1; i <= 30 && n < 0; i++) begin
      pause = (i >= 4 && i <= 7);
      cyc();
      start = 1'b0;
      if (i == 5) check("t3_frozen", 32'(count_a), 32'd1);
      if (done_a === 1'b1) n = i;
    end
    pause = 1'b0;
    check("t3_done_latency", n, 32'd10);
    cyc();

    // limit 2 auto-reload, then abort
    start_run(2, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      wait_done((k == 1) ? 1 : 0, 30, n);
      check("t4_period", n, 32'd5);
      check("t4_runs", 32'(runs_a), 32'(k));
    end
    abort = 1'b1; cyc(); abort = 1'b0;
    check("t4_abort_count", 32'(count_a), 32'd0);
    check("t4_abort_busy", 32'(busy_a), 32'd0);
    check("t4_abort_runs", 32'(runs_a), 32'd4);
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (done_a === 1'b1) seen_done++;
    end
    check("t4_no_done", seen_done, 32'd0);

    // abort mid-run at count 4, then start+abort together in idle
    start_run(9, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      cyc();
      if (count_a === 4'd4) hit = 1'b1;
    end
    check("t5_reached_4", 32'(hit), 32'd1);
    abort = 1'b1; cyc(); abort = 1'b0;
    check("t5_abort_count", 32'(count_a), 32'd0);
    check("t5_abort_busy", 32'(busy_a), 32'd0);
    start = 1'b1; abort = 1'b1; cyc(); start = 1'b0; abort = 1'b0;
    check("t5_start_blocked", 32'(busy_a), 32'd0);

    // start held with a changed limit while busy
    limit = 4'd3; rep_in = 1'b0; start = 1'b1;
    cyc();
    limit = 4'd7;
    wait_done(1, 30, n);
    start = 1'b0;
    check("t6_ignore_latency", n, 32'd6);
    check("t6_ignore_count", 32'(count_a), 32'd3);
    cyc();

    // reset in the middle of a run
    start_run(9, 1'b0);
    cyc(); cyc(); cyc();
    reset = 1'b1; cyc(); reset = 1'b0;
    check("t6_rst_count", 32'(count_a), 32'd0);
    check("t6_rst_busy", 32'(busy_a), 32'd0);

    // 2-bit tally wraps after five runs
    start_run(0, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      wait_done((k == 1) ? 1 : 0, 20, n);
      check("t7_period", n, 32'd3);
    end
    check("t7_runs_wrap", 32'(runs_b), 32'd1);
    check("t7_runs_full", 32'(runs_a), 32'd5);
    abort = 1'b1; cyc(); abort = 1'b0;

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      start  = ($urandom_range(3) == 0);
      limit  = W'($urandom_range(15));
      rep_in = $urandom_range(1);
      pause  = ($urandom_range(3) == 0);
      abort  = ($urandom_range(40) == 0);
      reset  = ($urandom_range(600) == 0);
      cyc();
    end
    reset = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
